// File: rtl/capture_controller.sv
// capture_controller
// Single-frame capture sequencer in the pixel clock domain. Arms on a host
// start request, skips any frame already in flight, then crops the next full
// frame to a latched window and emits registered buffer write strobes and
// addresses for the in-window pixels.
//
// Ports
//   pixel_clock_in     pixel clock (only clock)
//   pixel_reset_n_in   asynchronous active-low reset
//   start_capture_in   single-cycle capture request
//   abort_in           single-cycle abort, overrides everything
//   frame_valid_in     sensor frame valid
//   line_valid_in      sensor line valid
//   x/y_offset_in      window first column / row
//   x/y_size_in        window width / height
//   write_enable_out   buffer write strobe (one cycle after the pixel)
//   address_out        buffer write address of the current strobe
//   capture_busy_out   high in ARMED or CAPTURING
//   image_valid_out    high in DONE
//   image_size_out     pixels written in the last capture
//   timeout_out        sticky: last arm timed out
//   overflow_out       sticky: buffer filled during capture
//
// state      | meaning
// -----------+----------------------------------------------
// IDLE       | waiting for start
// ARMED      | waiting for a fresh frame_valid rising edge
// CAPTURING  | cropping the frame, issuing buffer writes
// DONE       | frame complete, image_valid_out high
module capture_controller #(
  parameter int          X_WIDTH        = 10,
  parameter int          Y_WIDTH        = 10,
  parameter int          ADDR_WIDTH     = 16,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000
) (
  input  logic                  pixel_clock_in,
  input  logic                  pixel_reset_n_in,
  input  logic                  start_capture_in,
  input  logic                  abort_in,
  input  logic                  frame_valid_in,
  input  logic                  line_valid_in,
  input  logic [X_WIDTH-1:0]    x_offset_in,
  input  logic [Y_WIDTH-1:0]    y_offset_in,
  input  logic [X_WIDTH-1:0]    x_size_in,
  input  logic [Y_WIDTH-1:0]    y_size_in,
  output logic                  write_enable_out,
  output logic [ADDR_WIDTH-1:0] address_out,
  output logic                  capture_busy_out,
  output logic                  image_valid_out,
  output logic [ADDR_WIDTH:0]   image_size_out,
  output logic                  timeout_out,
  output logic                  overflow_out
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ARMED     = 2'd1,
    S_CAPTURING = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  localparam logic [X_WIDTH-1:0]  X_ONE   = {{(X_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [Y_WIDTH-1:0]  Y_ONE   = {{(Y_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [23:0]         TMR_END = TIMEOUT_CYCLES - 24'd1;

  state_t r_state;
  state_t w_next_state;

  logic                  r_fv_prev;
  logic                  r_lv_prev;
  logic [X_WIDTH-1:0]    r_x;
  logic [Y_WIDTH-1:0]    r_y;
  logic [X_WIDTH-1:0]    r_x_off;
  logic [Y_WIDTH-1:0]    r_y_off;
  logic [X_WIDTH-1:0]    r_x_size;
  logic [Y_WIDTH-1:0]    r_y_size;
  logic [ADDR_WIDTH:0]   r_count;
  logic [23:0]           r_timer;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_image_size;
  logic                  r_timeout;
  logic                  r_overflow;

  logic w_fv_rise;
  logic w_fv_fall;
  logic w_lv_fall;
  logic w_arm;
  logic w_timeout_hit;
  logic w_pixel;
  logic w_in_window;
  logic w_full;
  logic w_busy;
  logic w_image_valid;

  logic [X_WIDTH:0] w_x_end;
  logic [Y_WIDTH:0] w_y_end;

  assign w_fv_rise = frame_valid_in & ~r_fv_prev;
  assign w_fv_fall = ~frame_valid_in & r_fv_prev;
  assign w_lv_fall = ~line_valid_in & r_lv_prev;

  assign w_arm = start_capture_in & ((r_state == S_IDLE) | (r_state == S_DONE));

  // A fresh frame edge wins over an expiring timer in the same cycle.
  assign w_timeout_hit = (r_state == S_ARMED) & ~w_fv_rise & (r_timer == TMR_END);

  assign w_pixel = (r_state == S_CAPTURING) & frame_valid_in & line_valid_in;

  // Window ends are computed one bit wider so offset+size never wraps.
  assign w_x_end = {1'b0, r_x_off} + {1'b0, r_x_size};
  assign w_y_end = {1'b0, r_y_off} + {1'b0, r_y_size};

  assign w_in_window = ({1'b0, r_x} >= {1'b0, r_x_off}) & ({1'b0, r_x} < w_x_end) &
                       ({1'b0, r_y} >= {1'b0, r_y_off}) & ({1'b0, r_y} < w_y_end);

  // The count MSB sets once every buffer location has been written.
  assign w_full = r_count[ADDR_WIDTH];

  // State register
  always_ff @(posedge pixel_clock_in or negedge pixel_reset_n_in) begin
    if (!pixel_reset_n_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    if (abort_in) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:      if (start_capture_in) w_next_state = S_ARMED;
        S_ARMED: begin
          if (w_fv_rise)          w_next_state = S_CAPTURING;
          else if (w_timeout_hit) w_next_state = S_IDLE;
        end
        S_CAPTURING: if (w_fv_fall) w_next_state = S_DONE;
        S_DONE:      if (start_capture_in) w_next_state = S_ARMED;
        default:     w_next_state = S_IDLE;
      endcase
    end
  end

  // Output decode of the registered state
  always_comb begin
    w_busy        = 1'b0;
    w_image_valid = 1'b0;
    case (r_state)
      S_ARMED, S_CAPTURING: w_busy        = 1'b1;
      S_DONE:               w_image_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: edge history, window latch, counters, write port, status
  always_ff @(posedge pixel_clock_in or negedge pixel_reset_n_in) begin
    if (!pixel_reset_n_in) begin
      r_fv_prev    <= 1'b0;
      r_lv_prev    <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_x_off      <= '0;
      r_y_off      <= '0;
      r_x_size     <= '0;
      r_y_size     <= '0;
      r_count      <= '0;
      r_timer      <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_image_size <= '0;
      r_timeout    <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_fv_prev <= frame_valid_in;
      r_lv_prev <= line_valid_in;
      r_we      <= 1'b0;

      if (!abort_in) begin
        if (w_arm) begin
          r_x_off      <= x_offset_in;
          r_y_off      <= y_offset_in;
          r_x_size     <= x_size_in;
          r_y_size     <= y_size_in;
          r_timeout    <= 1'b0;
          r_overflow   <= 1'b0;
          r_image_size <= '0;
          r_timer      <= '0;
        end

        if (r_state == S_ARMED) begin
          if (w_fv_rise) begin
            r_x     <= '0;
            r_y     <= '0;
            r_count <= '0;
            r_addr  <= '0;
          end else if (w_timeout_hit) begin
            r_timeout <= 1'b1;
          end else begin
            r_timer <= r_timer + 24'd1;
          end
        end

        if (r_state == S_CAPTURING) begin
          if (w_pixel) begin
            if (r_x != {X_WIDTH{1'b1}}) r_x <= r_x + X_ONE;
            if (w_in_window) begin
              if (!w_full) begin
                r_we    <= 1'b1;
                r_addr  <= r_count[ADDR_WIDTH-1:0];
                r_count <= r_count + CNT_ONE;
              end else begin
                r_overflow <= 1'b1;
              end
            end
          end
          if (w_lv_fall) begin
            r_x <= '0;
            if (r_y != {Y_WIDTH{1'b1}}) r_y <= r_y + Y_ONE;
          end
          if (w_fv_fall) begin
            r_image_size <= r_count;
          end
        end
      end
    end
  end

  assign write_enable_out = r_we;
  assign address_out      = r_addr;
  assign capture_busy_out = w_busy;
  assign image_valid_out  = w_image_valid;
  assign image_size_out   = r_image_size;
  assign timeout_out      = r_timeout;
  assign overflow_out     = r_overflow;

endmodule

// File: tb/tb_capture_controller.sv
module tb_capture_controller;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        fv;
  logic        lv;
  logic [9:0]  xo, yo, xs, ys;

  logic        we16, busy16, valid16, to16, ovf16;
  logic [15:0] addr16;
  logic [16:0] size16;
  logic        we4, busy4, valid4, to4, ovf4;
  logic [3:0]  addr4;
  logic [4:0]  size4;

  int n_run;
  int n_fail;
  bit sel;

  logic [31:0] m_we, m_addr, m_busy, m_valid, m_size, m_to, m_ovf;

  capture_controller #(
    .X_WIDTH(10), .Y_WIDTH(10), .ADDR_WIDTH(16), .TIMEOUT_CYCLES(24'd100)
  ) dut (
    .pixel_clock_in(clk), .pixel_reset_n_in(rst_n),
    .start_capture_in(start), .abort_in(abort),
    .frame_valid_in(fv), .line_valid_in(lv),
    .x_offset_in(xo), .y_offset_in(yo), .x_size_in(xs), .y_size_in(ys),
    .write_enable_out(we16), .address_out(addr16),
    .capture_busy_out(busy16), .image_valid_out(valid16),
    .image_size_out(size16), .timeout_out(to16), .overflow_out(ovf16)
  );

  capture_controller #(
    .X_WIDTH(10), .Y_WIDTH(10), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(24'd100)
  ) dut4 (
    .pixel_clock_in(clk), .pixel_reset_n_in(rst_n),
    .start_capture_in(start), .abort_in(abort),
    .frame_valid_in(fv), .line_valid_in(lv),
    .x_offset_in(xo), .y_offset_in(yo), .x_size_in(xs), .y_size_in(ys),
    .write_enable_out(we4), .address_out(addr4),
    .capture_busy_out(busy4), .image_valid_out(valid4),
    .image_size_out(size4), .timeout_out(to4), .overflow_out(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    m_we    = sel ? 32'(we4)    : 32'(we16);
    m_addr  = sel ? 32'(addr4)  : 32'(addr16);
    m_busy  = sel ? 32'(busy4)  : 32'(busy16);
    m_valid = sel ? 32'(valid4) : 32'(valid16);
    m_size  = sel ? 32'(size4)  : 32'(size16);
    m_to    = sel ? 32'(to4)    : 32'(to16);
    m_ovf   = sel ? 32'(ovf4)   : 32'(ovf16);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input int x_o, input int y_o, input int x_s, input int y_s);
    xo = 10'(x_o); yo = 10'(y_o); xs = 10'(x_s); ys = 10'(y_s);
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // Drives one w x h frame and checks each write one cycle after its pixel.
  task automatic send_frame(input string tag, input int w, input int h, input int gap,
                            input int x_o, input int y_o, input int x_s, input int y_s,
                            input int cap, input int exp_size, input int exp_ovf);
    int  exp_a;
    int  n_we;
    bit  inwin;
    exp_a = 0;
    n_we  = 0;
    fv = 1'b1; lv = 1'b0;
    tick;
    chk({tag, " busy_at_rise"}, m_busy, 32'd1);
    tick;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        lv = 1'b1;
        tick;
        inwin = (c >= x_o) && (c < x_o + x_s) && (r >= y_o) && (r < y_o + y_s);
        if (m_we == 32'd1) n_we++;
        if (inwin && exp_a < cap) begin
          chk({tag, " we"}, m_we, 32'd1);
          chk({tag, " addr"}, m_addr, 32'(exp_a));
          exp_a++;
        end else begin
          chk({tag, " we_idle"}, m_we, 32'd0);
        end
      end
      lv = 1'b0;
      for (int g = 0; g < gap; g++) begin
        tick;
        chk({tag, " we_gap"}, m_we, 32'd0);
        chk({tag, " valid_gap"}, m_valid, 32'd0);
      end
    end
    fv = 1'b0;
    tick;
    chk({tag, " done_valid"}, m_valid, 32'd1);
    chk({tag, " done_busy"}, m_busy, 32'd0);
    chk({tag, " image_size"}, m_size, 32'(exp_size));
    chk({tag, " write_count"}, 32'(n_we), 32'(exp_size));
    chk({tag, " overflow"}, m_ovf, 32'(exp_ovf));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_run = 0; n_fail = 0; sel = 1'b0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; fv = 1'b0; lv = 1'b0;
    xo = '0; yo = '0; xs = '0; ys = '0;
    tick; tick;
    chk("rst we", m_we, 32'd0);
    chk("rst addr", m_addr, 32'd0);
    chk("rst busy", m_busy, 32'd0);
    chk("rst valid", m_valid, 32'd0);
    chk("rst size", m_size, 32'd0);
    chk("rst timeout", m_to, 32'd0);
    chk("rst overflow", m_ovf, 32'd0);
    rst_n = 1'b1;
    tick;

    // Full 8x4 frame, full window
    arm(0, 0, 8, 4);
    chk("full armed busy", m_busy, 32'd1);
    send_frame("full", 8, 4, 3, 0, 0, 8, 4, 65536, 32, 0);

    // Cropped window from DONE; valid must drop after the new start
    arm(2, 1, 3, 2);
    chk("crop valid_drop", m_valid, 32'd0);
    chk("crop size_cleared", m_size, 32'd0);
    send_frame("crop", 8, 4, 3, 2, 1, 3, 2, 65536, 6, 0);

    // Arm while a frame is already in flight: that frame is skipped
    fv = 1'b1; lv = 1'b1;
    tick; tick;
    arm(0, 0, 8, 4);
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("midarm no_write", m_we, 32'd0);
    end
    lv = 1'b0; fv = 1'b0;
    tick; tick;
    chk("midarm still_armed", m_busy, 32'd1);
    send_frame("midarm", 8, 4, 3, 0, 0, 8, 4, 65536, 32, 0);

    // Zero-width window writes nothing
    arm(0, 0, 0, 4);
    send_frame("zero", 8, 4, 3, 0, 0, 0, 4, 65536, 0, 0);

    // Overflow on the 4-bit address instance
    sel = 1'b1;
    arm(0, 0, 8, 4);
    send_frame("ovf", 8, 4, 3, 0, 0, 8, 4, 16, 16, 1);
    // Abort from DONE clears valid but keeps overflow sticky
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("ovf abort valid", m_valid, 32'd0);
    chk("ovf abort sticky", m_ovf, 32'd1);
    sel = 1'b0;

    // Timeout: IDLE at the 100th edge after arm
    arm(0, 0, 8, 4);
    for (int i = 0; i < 99; i++) tick;
    chk("tmo busy_99", m_busy, 32'd1);
    chk("tmo flag_99", m_to, 32'd0);
    tick;
    chk("tmo busy_100", m_busy, 32'd0);
    chk("tmo flag_100", m_to, 32'd1);
    arm(0, 0, 8, 4);
    chk("tmo cleared", m_to, 32'd0);
    chk("tmo rearm busy", m_busy, 32'd1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("tmo abort idle", m_busy, 32'd0);

    // Abort mid-line
    arm(0, 0, 8, 4);
    fv = 1'b1;
    tick; tick;
    lv = 1'b1;
    tick; tick; tick;
    chk("abort pre_we", m_we, 32'd1);
    chk("abort pre_addr", m_addr, 32'd2);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort we", m_we, 32'd0);
    chk("abort busy", m_busy, 32'd0);
    chk("abort valid", m_valid, 32'd0);
    tick;
    chk("abort we_after", m_we, 32'd0);
    lv = 1'b0; fv = 1'b0;
    tick;

    // Start and abort together: abort wins
    start = 1'b1; abort = 1'b1;
    tick;
    start = 1'b0; abort = 1'b0;
    chk("startabort busy", m_busy, 32'd0);
    tick;
    chk("startabort busy2", m_busy, 32'd0);

    // Reset mid-capture: outputs clear without waiting for an edge
    arm(0, 0, 8, 4);
    fv = 1'b1;
    tick; tick;
    lv = 1'b1;
    tick; tick;
    chk("rstmid pre_we", m_we, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid we", m_we, 32'd0);
    chk("rstmid addr", m_addr, 32'd0);
    chk("rstmid busy", m_busy, 32'd0);
    chk("rstmid valid", m_valid, 32'd0);
    chk("rstmid size", m_size, 32'd0);
    lv = 1'b0; fv = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    chk("rstmid idle_after", m_busy, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
